// File: rtl/sb_issue_stage_if.sv
// rtl/sb_issue_stage_if.sv - decode/issue/write-back signal bundle for sb_issue_stage
interface sb_issue_stage_if #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
);
    localparam int RIDX_W = $clog2(NREG);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                 i_flush;
    logic                 i_valid;
    logic                 o_ready;
    logic [PAYLOAD_W-1:0] i_payload;
    logic [XLEN-1:0]      i_pc;
    logic [RIDX_W-1:0]    i_rs1;
    logic [RIDX_W-1:0]    i_rs2;
    logic [RIDX_W-1:0]    i_rd;
    logic                 i_use_rs1;
    logic                 i_use_rs2;
    logic                 i_wr_rd;
    logic                 i_fu_sel;
    logic                 o_alu_valid;
    logic                 i_alu_ready;
    logic                 o_lsu_valid;
    logic                 i_lsu_ready;
    logic [PAYLOAD_W-1:0] o_iss_payload;
    logic [XLEN-1:0]      o_iss_pc;
    logic [RIDX_W-1:0]    o_iss_rd;
    logic [XLEN-1:0]      o_iss_rs1_data;
    logic [XLEN-1:0]      o_iss_rs2_data;
    logic                 i_wb_en;
    logic [RIDX_W-1:0]    i_wb_rd;
    logic [XLEN-1:0]      i_wb_data;
    logic [CNT_W-1:0]     o_count;
    logic                 o_hazard_stall;

    modport master (
        output i_flush, i_valid, i_payload, i_pc, i_rs1, i_rs2, i_rd,
               i_use_rs1, i_use_rs2, i_wr_rd, i_fu_sel, i_alu_ready, i_lsu_ready,
               i_wb_en, i_wb_rd, i_wb_data,
        input  o_ready, o_alu_valid, o_lsu_valid, o_iss_payload, o_iss_pc, o_iss_rd,
               o_iss_rs1_data, o_iss_rs2_data, o_count, o_hazard_stall
    );

    modport slave (
        input  i_flush, i_valid, i_payload, i_pc, i_rs1, i_rs2, i_rd,
               i_use_rs1, i_use_rs2, i_wr_rd, i_fu_sel, i_alu_ready, i_lsu_ready,
               i_wb_en, i_wb_rd, i_wb_data,
        output o_ready, o_alu_valid, o_lsu_valid, o_iss_payload, o_iss_pc, o_iss_rd,
               o_iss_rs1_data, o_iss_rs2_data, o_count, o_hazard_stall
    );
endinterface

// File: rtl/sb_issue_stage.sv
// rtl/sb_issue_stage.sv - in-order issue queue with busy-bit scoreboard and bypassed register file
module sb_issue_stage #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    sb_issue_stage_if.slave bus
);
    localparam int RIDX_W = $clog2(NREG);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [XLEN-1:0]      pc;
        logic [RIDX_W-1:0]    rs1;
        logic [RIDX_W-1:0]    rs2;
        logic [RIDX_W-1:0]    rd;
        logic                 use_rs1;
        logic                 use_rs2;
        logic                 wr_rd;
        logic                 fu_sel;
    } uop_t;

    uop_t              q_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   busy_eff;
    logic [XLEN-1:0]   rf [NREG];

    uop_t              head;
    uop_t              in_uop;
    logic              head_valid;
    logic              hazard;
    logic              ready;
    logic              enq;
    logic              alu_valid;
    logic              lsu_valid;
    logic              fire;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;

    assign in_uop = '{payload: bus.i_payload, pc: bus.i_pc, rs1: bus.i_rs1, rs2: bus.i_rs2,
                      rd: bus.i_rd, use_rs1: bus.i_use_rs1, use_rs2: bus.i_use_rs2,
                      wr_rd: bus.i_wr_rd, fu_sel: bus.i_fu_sel};

    assign head       = q_mem[rd_ptr];
    assign head_valid = (count != '0);
    assign ready      = (count < CNT_W'(DEPTH));
    assign enq        = bus.i_valid && ready && !bus.i_flush;

    // A write-back landing this cycle already releases its register for the head.
    always_comb begin
        wb_mask = '0;
        if (bus.i_wb_en) wb_mask[bus.i_wb_rd] = 1'b1;
    end

    assign busy_eff = busy & ~wb_mask;
    assign hazard   = (head.use_rs1 && busy_eff[head.rs1]) ||
                      (head.use_rs2 && busy_eff[head.rs2]) ||
                      (head.wr_rd   && busy_eff[head.rd]);

    assign alu_valid = head_valid && !hazard && !bus.i_flush && !head.fu_sel;
    assign lsu_valid = head_valid && !hazard && !bus.i_flush &&  head.fu_sel;
    assign fire      = (alu_valid && bus.i_alu_ready) || (lsu_valid && bus.i_lsu_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)  wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, fire};
        end
    end

    always_ff @(posedge clk) begin
        if (enq) q_mem[wr_ptr] <= in_uop;
    end

    // Set is applied after clear so an issuing writer keeps its register busy.
    always_comb begin
        busy_next = busy & ~wb_mask;
        if (fire && head.wr_rd && (head.rd != '0)) busy_next[head.rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.i_wb_en && (bus.i_wb_rd != '0)) begin
            rf[bus.i_wb_rd] <= bus.i_wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (head.use_rs1 && (head.rs1 != '0)) begin
            if (bus.i_wb_en && (bus.i_wb_rd == head.rs1)) rs1_data = bus.i_wb_data;
            else                                          rs1_data = rf[head.rs1];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (head.use_rs2 && (head.rs2 != '0)) begin
            if (bus.i_wb_en && (bus.i_wb_rd == head.rs2)) rs2_data = bus.i_wb_data;
            else                                          rs2_data = rf[head.rs2];
        end
    end

    assign bus.o_ready        = ready;
    assign bus.o_alu_valid    = alu_valid;
    assign bus.o_lsu_valid    = lsu_valid;
    assign bus.o_iss_payload  = head.payload;
    assign bus.o_iss_pc       = head.pc;
    assign bus.o_iss_rd       = head.rd;
    assign bus.o_iss_rs1_data = rs1_data;
    assign bus.o_iss_rs2_data = rs2_data;
    assign bus.o_count        = count;
    assign bus.o_hazard_stall = head_valid && hazard;
endmodule

// File: tb/tb_sb_issue_stage.sv
// tb/tb_sb_issue_stage.sv - scoreboard bench for sb_issue_stage
module tb_sb_issue_stage;
    localparam int XLEN = 32, NREG = 32, DEPTH = 4, PAYLOAD_W = 64;

    logic clk;
    logic rst_n;

    sb_issue_stage_if #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) bus();

    sb_issue_stage #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] payload;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        fu;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   max_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (int'(bus.o_count) > max_count) max_count = int'(bus.o_count);
            if (bus.o_alu_valid || bus.o_lsu_valid) begin
                n_checks++;
                if (bus.o_alu_valid && bus.o_lsu_valid) begin
                    n_fail++;
                    $display("FAIL both_valid: alu=%b lsu=%b required one-hot", bus.o_alu_valid, bus.o_lsu_valid);
                end
            end
            if ((bus.o_alu_valid && bus.i_alu_ready) || (bus.o_lsu_valid && bus.i_lsu_ready)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: payload=%h with empty scoreboard", bus.o_iss_payload);
                end else begin
                    e = sb.pop_front();
                    if (bus.o_iss_payload !== e.payload) begin
                        n_fail++;
                        $display("FAIL iss_payload: got %h required %h", bus.o_iss_payload, e.payload);
                    end
                    n_checks++;
                    if ({bus.o_iss_pc, bus.o_iss_rd} !== {e.pc, e.rd}) begin
                        n_fail++;
                        $display("FAIL iss_pc_rd: got %h/%0d required %h/%0d", bus.o_iss_pc, bus.o_iss_rd, e.pc, e.rd);
                    end
                    n_checks++;
                    if (bus.o_lsu_valid !== e.fu) begin
                        n_fail++;
                        $display("FAIL iss_fu: got lsu=%b required %b", bus.o_lsu_valid, e.fu);
                    end
                    n_checks++;
                    if ({bus.o_iss_rs1_data, bus.o_iss_rs2_data} !== {e.rs1d, e.rs2d}) begin
                        n_fail++;
                        $display("FAIL iss_operands: got %h/%h required %h/%h",
                                 bus.o_iss_rs1_data, bus.o_iss_rs2_data, e.rs1d, e.rs2d);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.i_flush = 0; bus.i_valid = 0; bus.i_payload = '0; bus.i_pc = '0;
        bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd = '0;
        bus.i_use_rs1 = 0; bus.i_use_rs2 = 0; bus.i_wr_rd = 0; bus.i_fu_sel = 0;
        bus.i_alu_ready = 1; bus.i_lsu_ready = 1;
        bus.i_wb_en = 0; bus.i_wb_rd = '0; bus.i_wb_data = '0;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.i_wb_en = en; bus.i_wb_rd = rd; bus.i_wb_data = data;
    endtask

    // Drives one uop for a cycle; pushes its expected issue only if it was accepted.
    task automatic enq_one(input logic [63:0] pl, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic wr, input logic fu,
                           input logic [31:0] d1, input logic [31:0] d2, output logic acc);
        exp_t e;
        bus.i_valid = 1; bus.i_payload = pl; bus.i_pc = pc;
        bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_rd = rd;
        bus.i_use_rs1 = u1; bus.i_use_rs2 = u2; bus.i_wr_rd = wr; bus.i_fu_sel = fu;
        @(negedge clk);
        acc = bus.o_ready && !bus.i_flush;
        @(posedge clk);
        if (acc) begin
            e.payload = pl; e.pc = pc; e.rd = rd; e.fu = fu; e.rs1d = d1; e.rs2d = d2;
            sb.push_back(e);
        end
        #1;
        bus.i_valid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.o_ready, bus.o_alu_valid, bus.o_lsu_valid, bus.o_hazard_stall, bus.o_count} !== {4'b1000, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/alu/lsu/stall/cnt=%b%b%b%b/%0d required 1000/0",
                     bus.o_ready, bus.o_alu_valid, bus.o_lsu_valid, bus.o_hazard_stall, bus.o_count);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if ({bus.o_ready, bus.o_alu_valid, bus.o_lsu_valid, bus.o_hazard_stall, bus.o_count} !== {4'b1000, 3'd0}) begin
            n_fail++;
            $display("FAIL post_reset_outputs: rdy/alu/lsu/stall/cnt=%b%b%b%b/%0d required 1000/0",
                     bus.o_ready, bus.o_alu_valid, bus.o_lsu_valid, bus.o_hazard_stall, bus.o_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic acc;
        max_count = 0;
        for (int i = 0; i < 4; i++)
            enq_one(64'hB2B0 + 64'(i), 32'h1000 + 32'(4 * i), 5'd1, 5'd2, 5'(10 + i),
                    0, 0, 0, 0, 32'h0, 32'h0, acc);
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left required 0", sb.size()); end
        n_checks++;
        if (max_count > 1) begin n_fail++; $display("FAIL b2b_max_count: got %0d required <=1", max_count); end
    endtask

    task automatic test_full_lsu();
        logic acc;
        exp_t e;
        bus.i_lsu_ready = 0;
        for (int i = 0; i < 4; i++)
            enq_one(64'hF000 + 64'(i), 32'h2000 + 32'(4 * i), 5'd0, 5'd0, 5'd0,
                    0, 0, 0, 1, 32'h0, 32'h0, acc);
        bus.i_valid = 1; bus.i_payload = 64'hF004; bus.i_pc = 32'h2010;
        bus.i_rd = 5'd0; bus.i_wr_rd = 0; bus.i_fu_sel = 1;
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_count !== 3'd4) begin
            n_fail++; $display("FAIL full_ready: ready=%b count=%0d required 0/4", bus.o_ready, bus.o_count);
        end
        @(posedge clk); #1;
        bus.i_lsu_ready = 1;
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL no_passthrough: ready=%b required 0", bus.o_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL fifth_accept: ready=%b required 1", bus.o_ready);
        end
        @(posedge clk);
        e.payload = 64'hF004; e.pc = 32'h2010; e.rd = 5'd0; e.fu = 1; e.rs1d = 0; e.rs2d = 0;
        sb.push_back(e);
        #1;
        bus.i_valid = 0;
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL lsu_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_raw_hazard();
        logic acc;
        enq_one(64'hA5, 32'h3000, 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 32'h0, 32'h0, acc);
        enq_one(64'hB5, 32'h3004, 5'd5, 5'd0, 5'd0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0, acc);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.o_hazard_stall !== 1'b1 || bus.o_alu_valid !== 1'b0) begin
                n_fail++; $display("FAIL raw_stall: stall=%b alu=%b required 1/0", bus.o_hazard_stall, bus.o_alu_valid);
            end
            @(posedge clk); #1;
        end
        wb(1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b0 || bus.o_alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL raw_release: stall=%b alu=%b required 0/1", bus.o_hazard_stall, bus.o_alu_valid);
        end
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL raw_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_waw_set_wins();
        logic acc;
        enq_one(64'hC7, 32'h4000, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 32'h0, 32'h0, acc);
        enq_one(64'hD7, 32'h4004, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 32'h0, 32'h0, acc);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL waw_stall: stall=%b required 1", bus.o_hazard_stall);
        end
        @(posedge clk); #1;
        wb(1, 5'd7, 32'h1111);
        enq_one(64'hE7, 32'h4008, 5'd7, 5'd0, 5'd0, 1, 0, 0, 0, 32'h77, 32'h0, acc);
        wb(0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL set_wins: stall=%b required 1 (x7 still busy)", bus.o_hazard_stall);
        end
        @(posedge clk); #1;
        wb(1, 5'd7, 32'h77);
        @(negedge clk);
        n_checks++;
        if (bus.o_alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL waw_release: alu=%b required 1", bus.o_alu_valid);
        end
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL waw_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_flush();
        logic acc;
        enq_one(64'hF3, 32'h5000, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 32'h0, 32'h0, acc);
        bus.i_lsu_ready = 0;
        for (int i = 0; i < 3; i++)
            enq_one(64'h5100 + 64'(i), 32'h5004 + 32'(4 * i), 5'd0, 5'd0, 5'd0,
                    0, 0, 0, 1, 32'h0, 32'h0, acc);
        bus.i_flush = 1; bus.i_valid = 1; bus.i_payload = 64'h5EED; bus.i_fu_sel = 0;
        @(negedge clk);
        n_checks++;
        if (bus.o_alu_valid !== 1'b0 || bus.o_lsu_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valids: alu=%b lsu=%b required 0/0", bus.o_alu_valid, bus.o_lsu_valid);
        end
        @(posedge clk); #1;
        bus.i_flush = 0; bus.i_valid = 0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (bus.o_count !== 3'd0 || bus.o_alu_valid !== 1'b0 || bus.o_lsu_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: count=%0d alu=%b lsu=%b required 0/0/0",
                               bus.o_count, bus.o_alu_valid, bus.o_lsu_valid);
        end
        @(posedge clk); #1;
        bus.i_lsu_ready = 1;
        enq_one(64'h6003, 32'h6000, 5'd3, 5'd0, 5'd0, 1, 0, 0, 0, 32'h333, 32'h0, acc);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL busy_kept: stall=%b required 1", bus.o_hazard_stall);
        end
        @(posedge clk); #1;
        wb(1, 5'd3, 32'h333);
        @(negedge clk);
        n_checks++;
        if (bus.o_alu_valid !== 1'b1 || bus.o_hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL busy_cleared: alu=%b stall=%b required 1/0", bus.o_alu_valid, bus.o_hazard_stall);
        end
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL flush_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_x0();
        logic acc;
        wb(1, 5'd0, 32'h1234);
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        enq_one(64'h7000, 32'h7000, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 32'h0, 32'h0, acc);
        wb(1, 5'd0, 32'h1234);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b0 || bus.o_alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL x0_nohazard: stall=%b alu=%b required 0/1", bus.o_hazard_stall, bus.o_alu_valid);
        end
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL x0_drain: %0d left required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        enq_one(64'h8009, 32'h8000, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 32'h0, 32'h0, acc);
        bus.i_lsu_ready = 0;
        for (int i = 0; i < 2; i++)
            enq_one(64'h8100 + 64'(i), 32'h8004 + 32'(4 * i), 5'd0, 5'd0, 5'd0,
                    0, 0, 0, 1, 32'h0, 32'h0, acc);
        #2;
        wb(1, 5'd9, 32'h99);
        rst_n = 0;
        #1;
        n_checks++;
        if (bus.o_count !== 3'd0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: count=%0d ready=%b required 0/1", bus.o_count, bus.o_ready);
        end
        sb.delete();
        @(posedge clk); #1;
        wb(0, 5'd0, 32'h0);
        rst_n = 1;
        bus.i_lsu_ready = 1;
        enq_one(64'h9009, 32'h9000, 5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 32'h0, 32'h0, acc);
        @(negedge clk);
        n_checks++;
        if (bus.o_hazard_stall !== 1'b0 || bus.o_alu_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_cleared: stall=%b alu=%b required 0/1", bus.o_hazard_stall, bus.o_alu_valid);
        end
        @(posedge clk); #1;
        drain();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL reset_drain: %0d left required 0", sb.size()); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_back_to_back();
        test_full_lsu();
        test_raw_hazard();
        test_waw_set_wins();
        test_flush();
        test_x0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_issue_stage.md
SB_ISSUE_STAGE -- requirements
Module: sb_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; RIDX_W = clog2(NREG).
REQ-003 SHALL have parameter DEPTH, default 4, issue-queue entries; power of two, >= 2.
REQ-004 SHALL have parameter PAYLOAD_W, default 64, opaque decoded-uop payload width.
REQ-005 SHALL have the following ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_flush  in  1  synchronous pipeline flush.
- i_valid / o_ready  in / out  1 / 1  decode-to-issue enqueue handshake.
- i_payload  in  PAYLOAD_W  decoded uop.
- i_pc  in  XLEN  instruction PC.
- i_rs1, i_rs2, i_rd  in  RIDX_W each  register indices.
- i_use_rs1, i_use_rs2, i_wr_rd  in  1 each  operand-use and writes-rd flags.
- i_fu_sel  in  1  0 = ALU, 1 = LSU.
- o_alu_valid / i_alu_ready  out / in  1 / 1  ALU issue handshake.
- o_lsu_valid / i_lsu_ready  out / in  1 / 1  LSU issue handshake.
- o_iss_payload, o_iss_pc, o_iss_rd  out  PAYLOAD_W, XLEN, RIDX_W  issued head entry, shared by both FUs.
- o_iss_rs1_data, o_iss_rs2_data  out  XLEN each  read operands.
- i_wb_en, i_wb_rd, i_wb_data  in  1, RIDX_W, XLEN  write-back port.
- o_count  out  clog2(DEPTH)+1  queue occupancy.
- o_hazard_stall  out  1  head entry valid but blocked by scoreboard.

Function
REQ-006 SHALL hold an in-order FIFO of DEPTH entries with wrapping read/write pointers and an occupancy counter.
REQ-007 SHALL assert o_ready = (o_count < DEPTH); no same-cycle pass-through when full.
REQ-008 SHALL enqueue on i_valid && o_ready; earliest issue of that entry is the next cycle; simultaneous enqueue+dequeue leaves o_count unchanged.
REQ-009 SHALL keep a NREG-bit busy scoreboard; busy[0] always 0.
REQ-010 SHALL compute hazard = (use_rs1 && busy'[rs1]) || (use_rs2 && busy'[rs2]) || (wr_rd && busy'[rd]) for the head entry, where busy'[r] = busy[r] && !(i_wb_en && i_wb_rd == r); index 0 never hazards.
REQ-011 SHALL drive o_alu_valid = head_valid && !hazard && !i_flush && (fu_sel == 0); o_lsu_valid likewise for fu_sel == 1; never both.
REQ-012 SHALL dequeue (fire) on valid && ready of the selected FU; a held-valid head SHALL keep all o_iss_* stable until fire.
REQ-013 SHALL on fire set busy[rd] if wr_rd && rd != 0; SHALL clear busy[i_wb_rd] on i_wb_en; when set and clear target the same register in the same cycle, set wins.
REQ-014 SHALL contain an NREG x XLEN register file written on i_wb_en (rd != 0); x0 reads 0.
REQ-015 SHALL read operands combinationally with write-back bypass: same-cycle i_wb_rd match returns i_wb_data; unused operands drive 0.
REQ-016 SHALL assert o_hazard_stall = head_valid && hazard.
REQ-017 SHALL on i_flush empty the queue (pointers and count to 0), drop any same-cycle enqueue, and deassert both valids that cycle; the scoreboard and register file SHALL NOT be modified by flush (in-flight results still write back).
REQ-018 SHALL make the issue path combinational from queue head; throughput is one issue per cycle when hazard-free and the FU is ready.

Reset
REQ-019 SHALL on rst_n low asynchronously clear the pointers, o_count, all busy bits and all registers to 0.
REQ-020 SHALL drive o_alu_valid = o_lsu_valid = o_hazard_stall = 0 and o_ready = 1 in reset and the first cycle after.
REQ-021 SHALL discard reset asserted mid-operation with no partial state retained; a write-back coincident with reset is lost.

Verification
REQ-022 Enqueue 4 ALU uops back-to-back, no dependencies, i_alu_ready = 1 -> issued on cycles 1-4 in order; o_count never exceeds 1.
REQ-023 i_lsu_ready = 0, enqueue 5 LSU uops with DEPTH = 4 -> o_ready = 0 after the 4th; the 5th is accepted the cycle after the first LSU fire.
REQ-024 Issue write to x5 (rd = 5), next uop reads rs1 = 5 -> o_hazard_stall = 1 until i_wb_en with rd = 5 and data 0xDEADBEEF; the dependent uop issues that same cycle with o_iss_rs1_data = 0xDEADBEEF.
REQ-025 x7 busy; head writes x7 while write-back to x7 arrives the same cycle -> head issues and busy[7] remains 1.
REQ-026 3 entries queued, i_flush pulsed with i_valid = 1 -> o_count = 0 next cycle, no FU valid; a pending busy[3] still clears on its later write-back.
REQ-027 Write-back x0 = 0x1234, then issue a read of x0 -> operand = 0, no hazard.
